// File: rtl/proc_mem_responder.sv
// proc_mem_responder: processor-side RAM, memory-mapped I/O and boot-load FSM
module proc_mem_responder #(
  parameter int ADDR_W = 7,
  parameter int CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] dout,
  input  logic        w,
  output logic [15:0] din,
  input  logic [9:0]  sw,
  output logic [9:0]  led,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        proc_hold,
  output logic        load_err
);
  typedef enum logic {RUN, LOAD} state_t;
  state_t state;
  logic [15:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] ptr;
  logic [9:0] sw_meta, sw_sync;
  logic [CNT_W-1:0] cnt;
  logic [3:0] sel;
  logic [15:0] rd;
  logic load, pwr, unused;
  assign sel = addr[15:12];
  assign load = state == LOAD;
  assign pwr = w && !load;
  assign unused = ^addr[11:ADDR_W];
  always_comb
    rd = sel == 4'h0 ? mem[addr[ADDR_W-1:0]] :
         sel == 4'h1 ? {6'b0, led} :
         sel == 4'h2 ? {6'b0, sw_sync} :
         sel == 4'h3 ? 16'(cnt) :
         sel == 4'h4 ? {14'b0, load_err, proc_hold} : 16'h0;
  // Single write port shared by the boot loader and the processor; reset blocks both.
  always_ff @(posedge clock)
    if (!reset) begin
      if (load && load_valid) mem[ptr] <= load_data;
      else if (pwr && sel == 4'h0) mem[addr[ADDR_W-1:0]] <= dout;
    end
  always_ff @(posedge clock)
    if (reset) begin
      din <= '0;
      led <= '0;
      cnt <= '0;
      proc_hold <= 1'b0;
      load_err <= 1'b0;
      state <= RUN;
      ptr <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      din <= load ? 16'h0 : rd;
      if (pwr && sel == 4'h1) led <= dout[9:0];
      if (!load) cnt <= (w && sel == 4'h3) ? '0 : cnt + CNT_W'(1);
      if (!load && load_start) begin
        state <= LOAD;
        ptr <= '0;
        proc_hold <= 1'b1;
        load_err <= 1'b0;
      end else if (load && load_valid) begin
        ptr <= ptr + ADDR_W'(1);
        if (&ptr && !load_last) load_err <= 1'b1;
        if (load_last) begin
          state <= RUN;
          proc_hold <= 1'b0;
        end
      end
    end
endmodule
